// File: rtl/bp_pkg.sv
// Shared types and constants for the branch predictor: counter encodings,
// the BTB entry layout and default sizing.
package bp_pkg;

   localparam int DEF_IDX_W = 4;
   localparam int DEF_CNT_W = 16;
   localparam int MAX_TAG_W = 30;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } bp_ctr_t;

   localparam bp_ctr_t CTR_RESET = WNT;
   localparam bp_ctr_t CTR_ALLOC = WT;

   // The tag field is sized for the smallest index so any IDX_W fits; unused upper bits stay zero.
   typedef struct packed {
      logic                 valid;
      logic [MAX_TAG_W-1:0] tag;
      logic [31:0]          target;
      bp_ctr_t              ctr;
   } btb_entry_t;

   localparam btb_entry_t RESET_ENTRY = '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_RESET};

   function automatic logic [MAX_TAG_W-1:0] pc_tag(input logic [31:0] pc, input int idx_w);
      return MAX_TAG_W'(pc >> (idx_w + 2));
   endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Two-bit saturating counter next-state function: step towards ST when
// taken, towards SNT when not taken, holding at either end.
module bp_sat_counter
   import bp_pkg::*;
(
   input  bp_ctr_t ctr,
   input  logic    taken,
   output bp_ctr_t ctr_next
);

   always_comb begin
      ctr_next = ctr;
      if (taken) begin
         if (ctr != ST) ctr_next = bp_ctr_t'(ctr + 2'd1);
      end else begin
         if (ctr != SNT) ctr_next = bp_ctr_t'(ctr - 2'd1);
      end
   end

endmodule

// File: rtl/branch_predictor_ctrl.sv
// Direct-mapped BTB with 2-bit counters: combinational lookup for the fetch PC,
// training from the execute stage, and saturating branch/mispredict statistics.
module branch_predictor_ctrl
   import bp_pkg::*;
#(
   parameter int IDX_W = DEF_IDX_W,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      PCF,
   output logic             BranchPredicted,
   output logic [31:0]      PredTargetF,
   input  logic             UpdateE,
   input  logic [31:0]      PCE,
   input  logic             BranchTakenE,
   input  logic [31:0]      BTAE,
   input  logic             BranchPredictedE,
   output logic             MispredictE,
   output logic [CNT_W-1:0] BranchCount,
   output logic [CNT_W-1:0] MispredictCount
);

   localparam int N = 1 << IDX_W;

   btb_entry_t btb_q [N];
   btb_entry_t btb_d [N];

   logic [CNT_W-1:0] branch_count_q, branch_count_d;
   logic [CNT_W-1:0] mispredict_count_q, mispredict_count_d;

   logic [IDX_W-1:0]     idx_f, idx_e;
   logic [MAX_TAG_W-1:0] tag_f, tag_e;
   btb_entry_t           entry_f, entry_e;
   logic                 hit_f, hit_e;
   bp_ctr_t              ctr_next_e;

   assign idx_f   = PCF[IDX_W+1:2];
   assign idx_e   = PCE[IDX_W+1:2];
   assign tag_f   = pc_tag(PCF, IDX_W);
   assign tag_e   = pc_tag(PCE, IDX_W);
   assign entry_f = btb_q[idx_f];
   assign entry_e = btb_q[idx_e];
   assign hit_f   = entry_f.valid && (entry_f.tag == tag_f);
   assign hit_e   = entry_e.valid && (entry_e.tag == tag_e);

   assign BranchPredicted = hit_f && entry_f.ctr[1];
   assign PredTargetF     = BranchPredicted ? entry_f.target : 32'h0;
   assign MispredictE     = UpdateE && (BranchPredictedE != BranchTakenE);

   bp_sat_counter u_sat_counter (
      .ctr      (entry_e.ctr),
      .taken    (BranchTakenE),
      .ctr_next (ctr_next_e)
   );

   always_comb begin
      btb_d = btb_q;
      if (UpdateE) begin
         if (hit_e) begin
            btb_d[idx_e].ctr = ctr_next_e;
            if (BranchTakenE) btb_d[idx_e].target = BTAE;
         end else if (BranchTakenE) begin
            // A taken miss evicts whatever lived at this index.
            btb_d[idx_e] = '{valid: 1'b1, tag: tag_e, target: BTAE, ctr: CTR_ALLOC};
         end
      end
   end

   always_comb begin
      branch_count_d     = branch_count_q;
      mispredict_count_d = mispredict_count_q;
      if (UpdateE && (branch_count_q != '1))
         branch_count_d = branch_count_q + CNT_W'(1);
      if (MispredictE && (mispredict_count_q != '1))
         mispredict_count_d = mispredict_count_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N; i++) btb_q[i] <= RESET_ENTRY;
         branch_count_q     <= '0;
         mispredict_count_q <= '0;
      end else begin
         btb_q              <= btb_d;
         branch_count_q     <= branch_count_d;
         mispredict_count_q <= mispredict_count_d;
      end
   end

   assign BranchCount     = branch_count_q;
   assign MispredictCount = mispredict_count_q;

endmodule
